dp_ram_be_init: RTL and testbench
=================================

Name: dp_ram_be_init

Overview:
- Single-clock true dual-port RAM; next generation of the team's simple SP/DP RAMs.
- Adds per-byte write enables and per-port read enables with a `qvalid` pipeline.
- Adds a selectable read-during-write mode, an optional output register stage, and a hardware fill engine that writes INIT_VAL to every word after reset or on request.
- Used as the generic buffer and table store under DSP and datapath blocks.

Parameters:
- DW, 32, word width in bits; must be a multiple of BW.
- BW, 8, byte-lane width; NB = DW/BW lanes.
- WORDS, 256, depth; AW = $clog2(WORDS).
- RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new word), 2 = no-change (qout holds).
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_VAL, 0, DW-bit fill value written by the fill engine.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  one-cycle pulse; starts a fill pass when the block is ready.
- ready  out  1  high when the fill engine is idle and user accesses are accepted.
- addr_a  in  AW  port A address.
- rd_a  in  1  port A read enable.
- be_a  in  NB  port A byte write enables (any bit set means write).
- din_a  in  DW  port A write data.
- qout_a  out  DW  port A read data.
- qvalid_a  out  1  port A read data valid.
- addr_b, rd_b, be_b, din_b, qout_b, qvalid_b: same as port A, for port B.

Behaviour:
- Reset (async assert, sync release): qout_a/b = 0, qvalid_a/b = 0, ready = 0, FSM = FILL, fill address = 0.
  - Memory contents are not reset directly; the fill pass rewrites them.
- FSM states:
  - FILL: each cycle writes INIT_VAL to the fill address, then increments it.
    - At address WORDS-1 the write completes and the FSM goes to IDLE; ready rises the following cycle.
    - A fill pass takes exactly WORDS cycles from reset release.
  - IDLE: ready = 1.
    - clr_req = 1 → FILL at address 0; ready drops the next cycle.
    - User accesses presented in the clr_req cycle are still executed.
  - clr_req while ready = 0 is ignored; a pass is never restarted mid-way.
- While ready = 0:
  - User writes are dropped and reads are not issued.
  - qvalid stays 0; qout holds its last value.
- Read path:
  - rd_x at edge N → qout_x/qvalid_x valid after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
  - qvalid_x is a pure pipelined copy of an accepted rd_x.
  - Without an accepted read, qout holds (and qvalid is 0).
- Write: lane i of word addr_x is updated with din_x[i*BW +: BW] when be_x[i] = 1; other lanes are unchanged.
- Same-port read + write, same cycle:
  - RD_MODE 0: old word.
  - RD_MODE 1: old word with the enabled lanes replaced by din.
  - RD_MODE 2: qout and qvalid hold; qvalid = 0 for that read.
- Cross-port read of an address written by the other port in the same cycle: always returns the old word.
- Both ports write the same address in the same cycle:
  - Lanes enabled on A take din_a.
  - Lanes enabled only on B take din_b.
  - Port A has lane priority.
- Reset asserted mid-fill or mid-read: the pipeline is flushed immediately and the fill restarts from address 0 after release.

Optional Feature:
- Macro: DP_RAM_COLLISION_DET_EN.
- Defined:
  - Adds output coll (1 bit), registered: pulses high one cycle after any accepted cycle where addr_a == addr_b and at least one port writes while the other reads or writes.
  - Adds output coll_cnt (16 bits), saturating count of those events; cleared by reset and by clr_req.
- Undefined: neither port exists; data behaviour is identical.

Test Plan:
- Fill after reset: WORDS=16, INIT_VAL=32'hA5A5A5A5, release rst_n → ready rises on cycle 17 after release; reads of 0..15 all return A5A5A5A5 with qvalid one cycle later (OUT_REG=0), two cycles later (OUT_REG=1).
- Byte enables: write addr 3 din 32'h11223344 be 4'b0101 over A5A5A5A5 → read returns A522A544.
- RD_MODE sweep: write addr 5 din 32'hDEADBEEF be 4'hF with rd=1, old word 0 → qout = 0 (mode 0); DEADBEEF (mode 1); qvalid = 0 and qout unchanged (mode 2).
- Dual-write collision: same cycle A be 4'b0011 din 32'h0000AAAA, B be 4'b1110 din 32'hBBBB0000 at addr 7 → word = 0xBBB?AAAA with lane 1 = AA, i.e. 32'hBBBBAAAA.
  - With DP_RAM_COLLISION_DET_EN: coll pulses once and coll_cnt = 1.
- clr_req at runtime: after writes, pulse clr_req → ready low for WORDS cycles, writes during that time dropped, all words read back INIT_VAL.
  - A second clr_req mid-fill is ignored; the pass length stays WORDS.
- Async reset mid-fill at fill address 8 → qvalid, qout and ready go 0 immediately; the fill restarts from address 0 and takes a full WORDS cycles.

Source files
------------

// File: rtl/dp_ram_be_init_if.sv
// Port bundle for dp_ram_be_init; coll/coll_cnt exist only when DP_RAM_COLLISION_DET_EN is defined.
interface dp_ram_be_init_if #(
  parameter int DW    = 32,
  parameter int BW    = 8,
  parameter int WORDS = 256
);
  localparam int NB = DW / BW;
  localparam int AW = $clog2(WORDS);

  logic          clr_req;
  logic          ready;
  logic [AW-1:0] addr_a, addr_b;
  logic          rd_a, rd_b;
  logic [NB-1:0] be_a, be_b;
  logic [DW-1:0] din_a, din_b;
  logic [DW-1:0] qout_a, qout_b;
  logic          qvalid_a, qvalid_b;
`ifdef DP_RAM_COLLISION_DET_EN
  logic          coll;
  logic [15:0]   coll_cnt;

  modport master (
    output clr_req, addr_a, rd_a, be_a, din_a, addr_b, rd_b, be_b, din_b,
    input  ready, qout_a, qvalid_a, qout_b, qvalid_b, coll, coll_cnt
  );
  modport slave (
    input  clr_req, addr_a, rd_a, be_a, din_a, addr_b, rd_b, be_b, din_b,
    output ready, qout_a, qvalid_a, qout_b, qvalid_b, coll, coll_cnt
  );
`else
  modport master (
    output clr_req, addr_a, rd_a, be_a, din_a, addr_b, rd_b, be_b, din_b,
    input  ready, qout_a, qvalid_a, qout_b, qvalid_b
  );
  modport slave (
    input  clr_req, addr_a, rd_a, be_a, din_a, addr_b, rd_b, be_b, din_b,
    output ready, qout_a, qvalid_a, qout_b, qvalid_b
  );
`endif
endinterface

// File: rtl/dp_ram_be_init.sv
// True dual-port RAM with byte enables, read-during-write modes, optional output register and fill engine.
// Optional collision detector: define DP_RAM_COLLISION_DET_EN.
// state | meaning
// FILL  | writing INIT_VAL at fill_addr each cycle; user accesses dropped
// IDLE  | ready; user accesses accepted; clr_req starts a new fill pass
module dp_ram_be_init #(
  parameter int            DW       = 32,
  parameter int            BW       = 8,
  parameter int            WORDS    = 256,
  parameter int            RD_MODE  = 0,
  parameter int            OUT_REG  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  dp_ram_be_init_if.slave bus
);
  localparam int NB = DW / BW;
  localparam int AW = $clog2(WORDS);

  typedef enum logic {ST_FILL, ST_IDLE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fill_addr, fill_addr_nxt;
  logic [DW-1:0] mem [WORDS];
  logic          acc;

  logic [AW-1:0] addr  [2];
  logic          rd    [2];
  logic [NB-1:0] be    [2];
  logic [DW-1:0] din   [2];
  logic          wr    [2];
  logic          rd_ok [2];
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] q     [2];
  logic          qv    [2];

  assign addr[0] = bus.addr_a;
  assign addr[1] = bus.addr_b;
  assign rd[0]   = bus.rd_a;
  assign rd[1]   = bus.rd_b;
  assign be[0]   = bus.be_a;
  assign be[1]   = bus.be_b;
  assign din[0]  = bus.din_a;
  assign din[1]  = bus.din_b;

  assign acc       = (state == ST_IDLE);
  assign bus.ready = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      fill_addr <= '0;
    end else begin
      state     <= state_nxt;
      fill_addr <= fill_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fill_addr_nxt = fill_addr;
    case (state)
      ST_FILL: begin
        fill_addr_nxt = fill_addr + 1'b1;
        if (fill_addr == AW'(WORDS - 1)) begin
          state_nxt     = ST_IDLE;
          fill_addr_nxt = '0;
        end
      end
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_nxt     = ST_FILL;
          fill_addr_nxt = '0;
        end
      end
    endcase
  end

  // A no-change read that coincides with a write on the same port is simply not issued.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr[p]    = acc && (|be[p]);
      rd_ok[p] = acc && rd[p] && !(RD_MODE == 2 && wr[p]);
      rdata[p] = mem[addr[p]];
      if (RD_MODE == 1 && wr[p]) begin
        for (int i = 0; i < NB; i++) begin
          if (be[p][i]) rdata[p][i*BW +: BW] = din[p][i*BW +: BW];
        end
      end
    end
  end

  // Port A lanes are written last so they win on a same-address dual write.
  always_ff @(posedge clk) begin
    if (state == ST_FILL) mem[fill_addr] <= INIT_VAL;
    for (int i = 0; i < NB; i++) begin
      if (wr[1] && be[1][i]) mem[addr[1]][i*BW +: BW] <= din[1][i*BW +: BW];
      if (wr[0] && be[0][i]) mem[addr[0]][i*BW +: BW] <= din[0][i*BW +: BW];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] s1_q [2];
    logic          s1_v [2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          s1_q[p] <= '0;
          s1_v[p] <= 1'b0;
          q[p]    <= '0;
          qv[p]   <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          s1_v[p] <= rd_ok[p];
          if (rd_ok[p]) s1_q[p] <= rdata[p];
          qv[p] <= s1_v[p];
          if (s1_v[p]) q[p] <= s1_q[p];
        end
      end
    end
  end else begin : g_nreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          q[p]  <= '0;
          qv[p] <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          qv[p] <= rd_ok[p];
          if (rd_ok[p]) q[p] <= rdata[p];
        end
      end
    end
  end

  assign bus.qout_a   = q[0];
  assign bus.qout_b   = q[1];
  assign bus.qvalid_a = qv[0];
  assign bus.qvalid_b = qv[1];

`ifdef DP_RAM_COLLISION_DET_EN
  logic        coll_nxt;
  logic        coll_q;
  logic [15:0] coll_cnt_q;

  assign coll_nxt = acc && (addr[0] == addr[1]) &&
                    ((wr[0] && (rd[1] || wr[1])) || (wr[1] && rd[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll_nxt;
      if (acc && bus.clr_req)                coll_cnt_q <= '0;
      else if (coll_nxt && coll_cnt_q != '1) coll_cnt_q <= coll_cnt_q + 1'b1;
    end
  end

  assign bus.coll     = coll_q;
  assign bus.coll_cnt = coll_cnt_q;
`endif
endmodule

// File: tb/tb_dp_ram_be_init.sv
// Bench for dp_ram_be_init: three instances (read-first/lat1, write-first/lat2, no-change/lat1) against one reference model.
module tb_dp_ram_be_init;
  localparam int          WORDS = 16;
  localparam logic [31:0] INIT  = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dp_ram_be_init_if #(.DW(32), .BW(8), .WORDS(WORDS)) bus0 ();
  dp_ram_be_init_if #(.DW(32), .BW(8), .WORDS(WORDS)) bus1 ();
  dp_ram_be_init_if #(.DW(32), .BW(8), .WORDS(WORDS)) bus2 ();

  dp_ram_be_init #(.DW(32), .BW(8), .WORDS(WORDS), .RD_MODE(0), .OUT_REG(0), .INIT_VAL(INIT))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dp_ram_be_init #(.DW(32), .BW(8), .WORDS(WORDS), .RD_MODE(1), .OUT_REG(1), .INIT_VAL(INIT))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dp_ram_be_init #(.DW(32), .BW(8), .WORDS(WORDS), .RD_MODE(2), .OUT_REG(0), .INIT_VAL(INIT))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] obs_q [3][2];
  logic        obs_v [3][2];
  assign obs_q[0][0] = bus0.qout_a;   assign obs_q[0][1] = bus0.qout_b;
  assign obs_q[1][0] = bus1.qout_a;   assign obs_q[1][1] = bus1.qout_b;
  assign obs_q[2][0] = bus2.qout_a;   assign obs_q[2][1] = bus2.qout_b;
  assign obs_v[0][0] = bus0.qvalid_a; assign obs_v[0][1] = bus0.qvalid_b;
  assign obs_v[1][0] = bus1.qvalid_a; assign obs_v[1][1] = bus1.qvalid_b;
  assign obs_v[2][0] = bus2.qvalid_a; assign obs_v[2][1] = bus2.qvalid_b;

  int checks;
  int errors;

  // reference model state
  logic [31:0] m_mem [WORDS];
  bit          m_ready;
  int          fill_rem;
  logic [31:0] e_q [3][2];
  bit          e_v [3][2];
  logic [31:0] p_q [3][2];
  bit          p_v [3][2];
  bit          e_coll;
  logic [15:0] e_cnt;

  // current stimulus
  bit          s_clr;
  logic [3:0]  s_a   [2];
  bit          s_rd  [2];
  logic [3:0]  s_be  [2];
  logic [31:0] s_din [2];

  function automatic int mode_of(input int k);
    return k;
  endfunction

  function automatic bit oreg_of(input int k);
    return (k == 1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic [3:0] aa, input logic ra, input logic [3:0] bea,
                       input logic [31:0] da, input logic [3:0] ab, input logic rb,
                       input logic [3:0] beb, input logic [31:0] db);
    s_clr = clr; s_a[0] = aa; s_rd[0] = ra; s_be[0] = bea; s_din[0] = da;
    s_a[1] = ab; s_rd[1] = rb; s_be[1] = beb; s_din[1] = db;
    bus0.clr_req = clr; bus1.clr_req = clr; bus2.clr_req = clr;
    bus0.addr_a = aa;  bus1.addr_a = aa;  bus2.addr_a = aa;
    bus0.rd_a = ra;    bus1.rd_a = ra;    bus2.rd_a = ra;
    bus0.be_a = bea;   bus1.be_a = bea;   bus2.be_a = bea;
    bus0.din_a = da;   bus1.din_a = da;   bus2.din_a = da;
    bus0.addr_b = ab;  bus1.addr_b = ab;  bus2.addr_b = ab;
    bus0.rd_b = rb;    bus1.rd_b = rb;    bus2.rd_b = rb;
    bus0.be_b = beb;   bus1.be_b = beb;   bus2.be_b = beb;
    bus0.din_b = db;   bus1.din_b = db;   bus2.din_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'h0, 32'h0, 4'd0, 1'b0, 4'h0, 32'h0);
  endtask

  // Advance the model by one clock edge using the stimulus presented before that edge.
  task automatic model_edge();
    logic [31:0] old [2];
    bit          wr  [2];
    logic [31:0] d;
    bit          rok;
    bit          acc;
    bit          c;
    acc = m_ready;
    for (int p = 0; p < 2; p++) begin
      old[p] = m_mem[s_a[p]];
      wr[p]  = acc && (s_be[p] != 4'h0);
    end
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        rok = acc && s_rd[p] && !(mode_of(k) == 2 && wr[p]);
        d   = (mode_of(k) == 1 && wr[p]) ? merge(old[p], s_din[p], s_be[p]) : old[p];
        if (oreg_of(k)) begin
          if (p_v[k][p]) e_q[k][p] = p_q[k][p];
          e_v[k][p] = p_v[k][p];
          p_v[k][p] = rok;
          if (rok) p_q[k][p] = d;
        end else begin
          if (rok) e_q[k][p] = d;
          e_v[k][p] = rok;
        end
      end
    end
    c = acc && (s_a[0] == s_a[1]) && ((wr[0] && (s_rd[1] || wr[1])) || (wr[1] && s_rd[0]));
    e_coll = c;
    if (acc && s_clr)               e_cnt = 16'h0;
    else if (c && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'h1;
    if (acc) begin
      if (wr[1]) m_mem[s_a[1]] = merge(m_mem[s_a[1]], s_din[1], s_be[1]);
      if (wr[0]) m_mem[s_a[0]] = merge(m_mem[s_a[0]], s_din[0], s_be[0]);
      if (s_clr) begin
        m_ready  = 1'b0;
        fill_rem = WORDS;
      end
    end else begin
      m_mem[WORDS - fill_rem] = INIT;
      fill_rem--;
      if (fill_rem == 0) m_ready = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("ready", {31'h0, bus0.ready}, {31'h0, m_ready});
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("qout_u%0d_p%0d", k, p), obs_q[k][p], e_q[k][p]);
        chk($sformatf("qvalid_u%0d_p%0d", k, p), {31'h0, obs_v[k][p]}, {31'h0, e_v[k][p]});
      end
    end
`ifdef DP_RAM_COLLISION_DET_EN
    chk("coll", {31'h0, bus0.coll}, {31'h0, e_coll});
    chk("coll_cnt", {16'h0, bus0.coll_cnt}, {16'h0, e_cnt});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        e_q[k][p] = 32'h0; e_v[k][p] = 1'b0;
        p_q[k][p] = 32'h0; p_v[k][p] = 1'b0;
      end
    end
    m_ready  = 1'b0;
    fill_rem = WORDS;
    e_coll   = 1'b0;
    e_cnt    = 16'h0;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Steps through a fill pass while attempting writes that must be dropped; checks the pass length.
  task automatic wait_fill(input string tag, input bit clr_mid);
    int n;
    n = 0;
    while (bus0.ready !== 1'b1 && n < 40) begin
      drive(clr_mid && (n == 5), 4'($urandom_range(0, 15)), 1'b1, 4'hF, $urandom,
            4'($urandom_range(0, 15)), 1'b1, 4'h3, $urandom);
      step();
      n++;
    end
    chk(tag, n, WORDS);
    idle();
  endtask

  task automatic read_all_init(input string tag);
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b0, 4'(i), 1'b1, 4'h0, 32'h0, 4'(WORDS - 1 - i), 1'b1, 4'h0, 32'h0);
      step();
      chk(tag, bus0.qout_a, INIT);
    end
    idle();
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] ra_addr, rb_addr;
    int         n;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    for (int i = 0; i < WORDS; i++) m_mem[i] = 32'h0;
    idle();

    do_reset();
    wait_fill("fill_len_por", 1'b0);
    read_all_init("por_read");

    drive(1'b0, 4'd3, 1'b0, 4'b0101, 32'h11223344, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
    drive(1'b0, 4'd3, 1'b1, 4'h0, 32'h0, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
    idle();
    step();
    chk("be_u0", bus0.qout_a, 32'hA522A544);
    chk("be_u1", bus1.qout_a, 32'hA522A544);
    chk("be_u2", bus2.qout_a, 32'hA522A544);

    drive(1'b0, 4'd5, 1'b0, 4'hF, 32'h0, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
    drive(1'b0, 4'd5, 1'b1, 4'hF, 32'hDEADBEEF, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
    chk("mode0_q", bus0.qout_a, 32'h0);
    chk("mode0_v", {31'h0, bus0.qvalid_a}, 32'h1);
    chk("mode2_v", {31'h0, bus2.qvalid_a}, 32'h0);
    chk("mode2_q", bus2.qout_a, 32'hA522A544);
    idle();
    step();
    chk("mode1_q", bus1.qout_a, 32'hDEADBEEF);
    chk("mode1_v", {31'h0, bus1.qvalid_a}, 32'h1);

    drive(1'b0, 4'd7, 1'b0, 4'b0011, 32'h0000AAAA, 4'd7, 1'b0, 4'b1110, 32'hBBBB0000);
    step();
`ifdef DP_RAM_COLLISION_DET_EN
    chk("dw_coll", {31'h0, bus0.coll}, 32'h1);
    chk("dw_coll_cnt", {16'h0, bus0.coll_cnt}, 32'h1);
`endif
    drive(1'b0, 4'd7, 1'b1, 4'h0, 32'h0, 4'd7, 1'b1, 4'h0, 32'h0);
    step();
    idle();
    step();
    chk("dw_word_a", bus0.qout_a, 32'hBBBBAAAA);
    chk("dw_word_b", bus0.qout_b, 32'hBBBBAAAA);

    drive(1'b1, 4'd2, 1'b1, 4'hF, 32'h12345678, 4'd9, 1'b1, 4'h0, 32'h0);
    step();
    wait_fill("fill_len_clr", 1'b1);
    read_all_init("clr_read");
`ifdef DP_RAM_COLLISION_DET_EN
    chk("clr_coll_cnt", {16'h0, bus0.coll_cnt}, 32'h0);
`endif

    for (int t = 0; t < 300; t++) begin
      ra_addr = 4'($urandom_range(0, 15));
      rb_addr = ($urandom_range(0, 3) == 0) ? ra_addr : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 49) == 0, ra_addr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0, $urandom,
            rb_addr, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0, $urandom);
      step();
    end
    idle();
    n = 0;
    while (bus0.ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("rand_settle", {31'h0, bus0.ready}, 32'h1);

    drive(1'b0, 4'd4, 1'b1, 4'h0, 32'h0, 4'd4, 1'b1, 4'h0, 32'h0);
    step();
    do_reset();
    wait_fill("fill_len_rst_read", 1'b0);

    drive(1'b1, 4'd0, 1'b0, 4'h0, 32'h0, 4'd0, 1'b0, 4'h0, 32'h0);
    step();
    idle();
    repeat (8) step();
    do_reset();
    wait_fill("fill_len_rst_fill", 1'b0);
    read_all_init("rst_fill_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
